odo_sbox_bank: RTL and testbench
================================

Name: odo_sbox_bank

Overview:
- Runtime-loadable, multi-lane S-box lookup bank: the parametrised successor of the fixed 6-bit ROM S-boxes.
- Odo regenerates its small (6-bit) and large (10-bit) S-boxes every epoch, so table contents arrive over a sequential load port instead of being baked in at synthesis.
- LANES independent lookups per cycle share one table.
- Sits between the Odo round-key/epoch generator (load side) and the substitution layer of the hash pipeline (lookup side).

Parameters:
- W, default 6: entry/index width; table depth is 2^W (6 = small S-box, 10 = large S-box).
- LANES, default 4: parallel lookups per cycle.
- OUT_REG, default 0: 1 adds an output register stage, so latency is 1+OUT_REG cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load_start  input  1  single-cycle pulse; begins a (re)load at entry 0
- load_valid  input  1  load_data holds the next table entry
- load_data  input  W  entry value written to mem[load_cnt]
- load_busy  output  1  high while state is LOAD
- table_ok  output  1  high when a complete table is resident
- table_gen  output  8  count of completed loads, wraps 255 -> 0
- in_valid  input  1  lookup request
- in_inv  input  1  inverse-lookup select; used only with ODO_SBOX_INV_EN
- in_data  input  LANES*W  lane k index at bits [k*W +: W]
- in_ready  output  1  request accepted when in_valid && in_ready
- out_valid  output  1  result valid
- out_data  output  LANES*W  lane k = mem[in_data lane k]

Behaviour:
- Reset values: state = EMPTY; load_busy = 0; table_ok = 0; table_gen = 0; out_valid = 0; out_data = 0; load_cnt = 0.
- Table memory is not reset. After reset its contents are undefined until a load completes.
- State machine:
  - EMPTY: in_ready = 0. load_start -> LOAD.
  - LOAD: in_ready = 0, load_busy = 1.
    - Each load_valid cycle writes mem[load_cnt] <= load_data, then load_cnt++.
    - When the write at load_cnt = 2^W-1 occurs: load_cnt -> 0, table_gen++, table_ok <= 1, next state READY.
  - READY: in_ready = 1. load_start -> LOAD with table_ok <= 0, load_cnt <= 0.
- load_start while in LOAD: aborts the current load and restarts at entry 0. table_gen is unchanged.
- load_start and load_valid in the same cycle: the restart takes priority; load_data is written to entry 0 and load_cnt becomes 1.
- load_valid outside LOAD is ignored.
- Lookups:
  - Accepted only in READY.
  - The memory read happens in the acceptance cycle. A load_start in that same cycle still returns old-table data for the accepted request.
  - In-flight results always complete with the table present at acceptance.
  - in_ready falls the cycle after load_start is seen.
- Latency and flow control:
  - out_valid / out_data appear exactly 1+OUT_REG cycles after acceptance.
  - Fully pipelined, one request per cycle; no output backpressure.
  - out_data holds its last value when out_valid = 0.
- Reset asserted mid-load or mid-lookup: immediate return to EMPTY with all reset values. In-flight results are discarded (out_valid = 0).
- Lanes are fully independent. Identical indices on several lanes return identical values with no conflict.

Optional Feature:
- Macro ODO_SBOX_INV_EN.
- Defined:
  - A second 2^W x W inverse table is written in parallel during LOAD: inv[load_data] <= load_cnt.
  - An accepted request with in_inv = 1 returns inv[index] on all lanes, with the same latency as a forward lookup.
  - Inverse results are well-defined only when the loaded table is a bijection; non-bijective loads give last-writer-wins contents.
- Undefined: no inverse memory is built and in_inv is ignored; forward lookup is always performed.

Test Plan:
- Reset then lookup attempt: in_valid = 1 with table_ok = 0 -> in_ready = 0, out_valid stays 0, table_gen = 0.
- W=6, LANES=4, OUT_REG=0, load mem[i] = i^0x2A. Lookup lanes {0x00,0x3F,0x15,0x2A} -> one cycle later out lanes {0x2A,0x15,0x3F,0x00}; table_gen = 1.
- Back-to-back lookups for 64 cycles with OUT_REG=1: every out_valid arrives 2 cycles after acceptance with correct data. Then load_start pulsed while 2 results are in flight: both return old-table values, and in_ready = 0 from the next cycle.
- Abort: load_start, 20 load_valid entries, load_start again, 64 entries of mem[i] = 63-i. Lookup of 0x00 -> 0x3F, 0x3F -> 0x00; table_gen increments by exactly 1.
- Reset mid-load (rst_n low after 30 entries): table_ok = 0, load_busy = 0, state EMPTY; the next full load succeeds.
- ODO_SBOX_INV_EN, load mem[i] = (i+5) mod 64: inverse lookup of {0x05,0x04,0x00,0x3F} -> {0x00,0x3F,0x3B,0x3A}; a forward lookup on the same cycle pattern is unaffected.

Source files
------------

// File: rtl/odo_sbox_bank_if.sv
// Load/lookup bus of the Odo S-box bank: the epoch generator drives the load side,
// the substitution layer drives the lookup side and consumes results.
interface odo_sbox_bank_if #(
  parameter int unsigned W     = 6,
  parameter int unsigned LANES = 4
);
  logic                 load_start;
  logic                 load_valid;
  logic [W-1:0]         load_data;
  logic                 load_busy;
  logic                 table_ok;
  logic [7:0]           table_gen;
  logic                 in_valid;
  logic                 in_inv;
  logic [LANES*W-1:0]   in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [LANES*W-1:0]   out_data;

  modport master (
    output load_start, load_valid, load_data, in_valid, in_inv, in_data,
    input  load_busy, table_ok, table_gen, in_ready, out_valid, out_data
  );

  modport slave (
    input  load_start, load_valid, load_data, in_valid, in_inv, in_data,
    output load_busy, table_ok, table_gen, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/odo_sbox_bank.sv
// Runtime-loadable multi-lane S-box lookup bank for the Odo hash pipeline.
// Optional inverse table built when ODO_SBOX_INV_EN is defined.
module odo_sbox_bank #(
  parameter int unsigned W       = 6,
  parameter int unsigned LANES   = 4,
  parameter int unsigned OUT_REG = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  odo_sbox_bank_if.slave   sbox_if
);

  localparam int unsigned DEPTH = 2 ** W;
  localparam int unsigned DW    = LANES * W;
  localparam logic [W-1:0] LAST_IDX = W'(DEPTH - 1);

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_e;

  state_e       state_q;
  logic [W-1:0] load_cnt_q;
  logic         load_busy_q;
  logic         table_ok_q;
  logic         in_ready_q;
  logic [7:0]   table_gen_q;

  logic [W-1:0] mem [DEPTH];

  logic          wr_en_c;
  logic [W-1:0]  wr_addr_c;
  logic          accept_c;
  logic [DW-1:0] rd_data_c;

  logic          s1_valid_q;
  logic [DW-1:0] s1_data_q;

  // A restart always lands its (optional) entry at index 0.
  assign wr_en_c   = sbox_if.load_valid && (sbox_if.load_start || state_q == LOAD);
  assign wr_addr_c = sbox_if.load_start ? '0 : load_cnt_q;
  assign accept_c  = sbox_if.in_valid && in_ready_q;

  // Load/lookup state machine; status outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      load_cnt_q  <= '0;
      load_busy_q <= 1'b0;
      table_ok_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      table_gen_q <= 8'd0;
    end else if (sbox_if.load_start) begin
      state_q     <= LOAD;
      load_busy_q <= 1'b1;
      table_ok_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      load_cnt_q  <= sbox_if.load_valid ? W'(1) : '0;
    end else if (state_q == LOAD && sbox_if.load_valid) begin
      if (load_cnt_q == LAST_IDX) begin
        state_q     <= READY;
        load_busy_q <= 1'b0;
        table_ok_q  <= 1'b1;
        in_ready_q  <= 1'b1;
        table_gen_q <= table_gen_q + 8'd1;
        load_cnt_q  <= '0;
      end else begin
        load_cnt_q  <= load_cnt_q + W'(1);
      end
    end
  end

  // Table storage carries no reset; it is meaningful only once table_ok is set.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_addr_c] <= sbox_if.load_data;
  end

`ifdef ODO_SBOX_INV_EN
  logic [W-1:0] inv [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_c) inv[sbox_if.load_data] <= wr_addr_c;
  end

  always_comb begin
    rd_data_c = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      rd_data_c[k*W +: W] = sbox_if.in_inv ? inv[sbox_if.in_data[k*W +: W]]
                                           : mem[sbox_if.in_data[k*W +: W]];
    end
  end
`else
  logic unused_in_inv;
  assign unused_in_inv = sbox_if.in_inv;

  always_comb begin
    rd_data_c = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      rd_data_c[k*W +: W] = mem[sbox_if.in_data[k*W +: W]];
    end
  end
`endif

  // Read happens in the acceptance cycle, so a same-cycle reload still sees the old table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= accept_c;
      if (accept_c) s1_data_q <= rd_data_c;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic          s2_valid_q;
      logic [DW-1:0] s2_data_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s1_valid_q;
          if (s1_valid_q) s2_data_q <= s1_data_q;
        end
      end

      assign sbox_if.out_valid = s2_valid_q;
      assign sbox_if.out_data  = s2_data_q;
    end else begin : g_no_out_reg
      assign sbox_if.out_valid = s1_valid_q;
      assign sbox_if.out_data  = s1_data_q;
    end
  endgenerate

  assign sbox_if.load_busy = load_busy_q;
  assign sbox_if.table_ok  = table_ok_q;
  assign sbox_if.table_gen = table_gen_q;
  assign sbox_if.in_ready  = in_ready_q;

endmodule

// File: tb/tb_odo_sbox_bank.sv
// Directed bench for odo_sbox_bank: one instance with OUT_REG=0 and one with OUT_REG=1,
// both fed the same stimulus. Inverse-table vectors run when ODO_SBOX_INV_EN is defined.
module tb_odo_sbox_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start, load_valid, in_valid, in_inv;
  logic [5:0]  load_data;
  logic [23:0] in_data;

  int n_checks = 0;
  int n_errors = 0;

  odo_sbox_bank_if #(.W(6), .LANES(4)) if0 ();
  odo_sbox_bank_if #(.W(6), .LANES(4)) if1 ();

  assign if0.load_start = load_start;  assign if1.load_start = load_start;
  assign if0.load_valid = load_valid;  assign if1.load_valid = load_valid;
  assign if0.load_data  = load_data;   assign if1.load_data  = load_data;
  assign if0.in_valid   = in_valid;    assign if1.in_valid   = in_valid;
  assign if0.in_inv     = in_inv;      assign if1.in_inv     = in_inv;
  assign if0.in_data    = in_data;     assign if1.in_data    = in_data;

  odo_sbox_bank #(.W(6), .LANES(4), .OUT_REG(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .sbox_if(if0));
  odo_sbox_bank #(.W(6), .LANES(4), .OUT_REG(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .sbox_if(if1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [5:0] a, b, c, d;
    a = 6'(l0); b = 6'(l1); c = 6'(l2); d = 6'(l3);
    return {d, c, b, a};
  endfunction

  // Table contents: 0 -> i^0x2A, 1 -> 63-i, 2 -> (i+5) mod 64
  function automatic logic [5:0] tval(input int kind, input int i);
    case (kind)
      0:       return 6'((i ^ 42) & 63);
      1:       return 6'(63 - i);
      default: return 6'((i + 5) % 64);
    endcase
  endfunction

  task automatic do_load(input int kind, input bit merged);
    load_start = 1'b1;
    load_valid = merged;
    load_data  = tval(kind, 0);
    tick();
    load_start = 1'b0;
    for (int i = (merged ? 1 : 0); i < 64; i++) begin
      load_valid = 1'b1;
      load_data  = tval(kind, i);
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic inv, input logic [23:0] idx,
                        input logic [23:0] exp);
    in_valid = 1'b1;
    in_inv   = inv;
    in_data  = idx;
    check({tag, "_rdy"}, if0.in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check({tag, "_v0"},  if0.out_valid, 1'b1);
    check({tag, "_d0"},  if0.out_data, exp);
    check({tag, "_v1e"}, if1.out_valid, 1'b0);
    tick();
    check({tag, "_v0e"}, if0.out_valid, 1'b0);
    check({tag, "_hold"}, if0.out_data, exp);
    check({tag, "_v1"},  if1.out_valid, 1'b1);
    check({tag, "_d1"},  if1.out_data, exp);
  endtask

  logic [23:0] req [64];
  logic [23:0] expd [64];

  initial begin
    rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    in_valid = 1'b0; in_inv = 1'b0; in_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state, then lookup attempts with no table
    check("rst_ok",   if0.table_ok, 1'b0);
    check("rst_busy", if0.load_busy, 1'b0);
    check("rst_gen",  if0.table_gen, 8'd0);
    check("rst_outd", if1.out_data, 24'h0);
    in_valid = 1'b1; in_data = 24'h123456;
    for (int i = 0; i < 3; i++) begin
      check("empty_rdy", if0.in_ready, 1'b0);
      tick();
      check("empty_v0", if0.out_valid, 1'b0);
      check("empty_v1", if1.out_valid, 1'b0);
    end
    in_valid = 1'b0;

    // First load: mem[i] = i ^ 0x2A
    do_load(0, 1'b0);
    check("ld1_ok",   if0.table_ok, 1'b1);
    check("ld1_gen",  if0.table_gen, 8'd1);
    check("ld1_busy", if0.load_busy, 1'b0);
    lookup("xor", 1'b0, pack4(8'h00, 8'h3F, 8'h15, 8'h2A), pack4(8'h2A, 8'h15, 8'h3F, 8'h00));

    // 64 back-to-back lookups
    for (int i = 0; i < 64; i++) begin
      req[i]  = pack4(i, i + 17, i + 34, i + 51);
      expd[i] = pack4(tval(0, i), tval(0, (i + 17) % 64), tval(0, (i + 34) % 64),
                      tval(0, (i + 51) % 64));
    end
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_data  = req[i];
      tick();
      check("st_v0", if0.out_valid, 1'b1);
      check("st_d0", if0.out_data, expd[i]);
      if (i == 0) begin
        check("st_v1_first", if1.out_valid, 1'b0);
      end else begin
        check("st_v1", if1.out_valid, 1'b1);
        check("st_d1", if1.out_data, expd[i-1]);
      end
    end
    in_valid = 1'b0;
    tick();
    check("st_v1_last", if1.out_valid, 1'b1);
    check("st_d1_last", if1.out_data, expd[63]);
    check("st_v0_idle", if0.out_valid, 1'b0);
    tick();

    // Reload while two requests are in flight: both must return old-table data
    in_valid = 1'b1;
    in_data  = pack4(1, 2, 3, 4);
    tick();
    in_data    = pack4(8'h10, 8'h20, 8'h30, 8'h3F);
    load_start = 1'b1;
    check("fl_rdy_pre", if0.in_ready, 1'b1);
    tick();
    load_start = 1'b0;
    in_data    = 24'h0;
    check("fl_rdy0",  if0.in_ready, 1'b0);
    check("fl_rdy1",  if1.in_ready, 1'b0);
    check("fl_busy",  if0.load_busy, 1'b1);
    check("fl_ok",    if0.table_ok, 1'b0);
    check("fl_v0",    if0.out_valid, 1'b1);
    check("fl_d0",    if0.out_data, pack4(8'h3A, 8'h0A, 8'h1A, 8'h15));
    check("fl_vA",    if1.out_valid, 1'b1);
    check("fl_dA",    if1.out_data, pack4(8'h2B, 8'h28, 8'h29, 8'h2E));
    tick();
    check("fl_vB",    if1.out_valid, 1'b1);
    check("fl_dB",    if1.out_data, pack4(8'h3A, 8'h0A, 8'h1A, 8'h15));
    check("fl_v0_no", if0.out_valid, 1'b0);
    tick();
    check("fl_v1_no", if1.out_valid, 1'b0);
    in_valid = 1'b0;

    // Abort after 20 entries; restart shares its cycle with entry 0 of mem[i] = 63-i
    for (int i = 0; i < 20; i++) begin
      load_valid = 1'b1;
      load_data  = tval(0, i);
      tick();
    end
    load_valid = 1'b0;
    check("ab_busy", if0.load_busy, 1'b1);
    check("ab_gen",  if0.table_gen, 8'd1);
    do_load(1, 1'b1);
    check("ab_gen2", if0.table_gen, 8'd2);
    check("ab_ok",   if0.table_ok, 1'b1);
    check("ab_rdy",  if0.in_ready, 1'b1);
    lookup("rev", 1'b0, pack4(8'h00, 8'h3F, 8'h00, 8'h3F), pack4(8'h3F, 8'h00, 8'h3F, 8'h00));

    // load_valid outside LOAD must not touch the table
    load_valid = 1'b1; load_data = 6'h11;
    tick(); tick();
    load_valid = 1'b0;
    check("ign_busy", if0.load_busy, 1'b0);
    lookup("ign", 1'b0, pack4(8'h00, 8'h01, 8'h3E, 8'h20), pack4(8'h3F, 8'h3E, 8'h01, 8'h1F));

    // Reset after 30 entries of a reload
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      load_valid = 1'b1;
      load_data  = tval(2, i);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("mr_ok",   if0.table_ok, 1'b0);
    check("mr_busy", if0.load_busy, 1'b0);
    check("mr_rdy",  if0.in_ready, 1'b0);
    check("mr_gen",  if0.table_gen, 8'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    load_valid = 1'b0;
    check("mr_busy2", if0.load_busy, 1'b0);
    check("mr_ok2",   if0.table_ok, 1'b0);
    do_load(0, 1'b0);
    check("mr_gen1", if0.table_gen, 8'd1);
    check("mr_ok3",  if0.table_ok, 1'b1);
    lookup("mr", 1'b0, pack4(8'h00, 8'h3F, 8'h15, 8'h2A), pack4(8'h2A, 8'h15, 8'h3F, 8'h00));

`ifdef ODO_SBOX_INV_EN
    do_load(2, 1'b0);
    check("inv_gen", if0.table_gen, 8'd2);
    lookup("inv", 1'b1, pack4(8'h05, 8'h04, 8'h00, 8'h3F), pack4(8'h00, 8'h3F, 8'h3B, 8'h3A));
    lookup("fwd", 1'b0, pack4(8'h05, 8'h04, 8'h00, 8'h3F), pack4(8'h0A, 8'h09, 8'h05, 8'h04));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
